p2p_result_collector: RTL
=========================

// Module: p2p_result_collector
// PURPOSE
//  Receiving end of the point-to-point multiply stream. Captures the serial
//  8-bit product stream from the multiplier into a SIZE-entry buffer and
//  accumulates the dot-product sum on the fly. It then streams the stored
//  products back out over a valid/ready handshake, ending each frame with a
//  last marker. Sits between the p2p multiplier output and the host/readback
//  path.
// PARAMETERS
//  SIZE   16  products per frame (buffer depth)
//  DW     8   product width
//  SUM_W  12  accumulator width = DW + clog2(SIZE); never overflows
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      reset, synchronous, active-low (rst==0 resets)
//  prod_in    in   DW     product sample from multiplier
//  prod_valid in   1      prod_in valid this cycle (no backpressure upstream)
//  done_in    in   1      multiplier frame-done; closes the frame
//  out_ready  in   1      downstream ready to accept out_data
//  out_data   out  DW     buffered product, registered
//  out_valid  out  1      out_data valid
//  out_last   out  1      marks the final product of the frame
//  sum_out    out  SUM_W  sum of all captured products in the frame
//  sum_valid  out  1      sum_out final; high throughout READOUT
//  busy       out  1      high in CAPTURE or READOUT
//  overrun    out  1      sticky; a sample arrived while it could not be stored
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, wr_cnt=rd_idx=0, sum=0. All
//   outputs are 0. Buffer contents are don't-care. Reset mid-frame aborts
//   the frame immediately; no partial output is produced.
//  FSM IDLE -> CAPTURE -> READOUT -> IDLE.
//  IDLE: prod_valid stores the sample at buf[0], sets sum=prod_in and
//   wr_cnt=1, then moves to CAPTURE. done_in alone (no samples) is ignored.
//  CAPTURE: each prod_valid writes buf[wr_cnt], adds prod_in to sum
//   (zero-extended), and increments wr_cnt.
//   -> READOUT when wr_cnt reaches SIZE, or on done_in (short frame,
//   frame_len=wr_cnt). prod_valid and done_in in the same cycle: the sample
//   is stored first, then the block transitions.
//  READOUT: sum_valid=1, sum_out is held. out_valid asserts one cycle after
//   READOUT is entered, with out_data=buf[0]. A beat transfers when
//   out_valid & out_ready. out_data/out_valid/out_last stay stable while
//   out_ready=0. out_last=1 only with rd_idx==frame_len-1. After the last
//   transfer, the next cycle is IDLE with out_valid, sum_valid and busy = 0.
//   The block does not return out_valid=0 between beats while out_ready is
//   held high; one beat per cycle.
//  Overrun: prod_valid in READOUT, or after wr_cnt==SIZE, sets overrun and
//   drops the sample. overrun clears only on reset.
//  done_in in IDLE or READOUT: ignored.
// STRUCTURE
//  Shared package p2p_pkg: P2P_SIZE, P2P_DW, P2P_SUM_W constants and the
//   collector state enum (ST_IDLE, ST_CAPTURE, ST_READOUT).
//  One sub-module: p2p_frame_buf. A SIZE x DW single-write/single-read
//   register-file RAM with a registered read port. FSM, counters and
//   accumulator stay in the top.
// TESTING
//  Full frame: prod 1..16 on consecutive cycles, out_ready=1 ->
//   sum_out=136, out_data 1..16, out_last on the 16th beat, then IDLE.
//  Backpressure: 16x 0xFF with out_ready toggling 1,0,0,1 ->
//   sum_out=0xFF0, outputs stable while stalled, exactly 16 beats.
//  Short frame: 5 samples 0x10..0x14, done_in with the 5th -> sum_out=0x5A,
//   out_last on the 5th beat (0x14).
//  Overrun: 17th prod_valid=0x33 during READOUT -> overrun=1, readout
//   unaffected, overrun persists after return to IDLE.
//  Reset mid-capture: rst=0 after 7 samples -> all outputs 0. A new 16-sample
//   frame then captures correctly from buf[0].
//  Gapped input: samples separated by 0-3 idle cycles -> same result as
//   back-to-back.

Source files
------------

// File: rtl/p2p_pkg.sv
// Shared constants and state encoding for the p2p result collector.
package p2p_pkg;
  localparam int P2P_SIZE  = 16;
  localparam int P2P_DW    = 8;
  localparam int P2P_SUM_W = P2P_DW + $clog2(P2P_SIZE);
  // Counter width must hold the value SIZE itself, not just SIZE-1.
  localparam int P2P_CNT_W = $clog2(P2P_SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2
  } st_e;
endpackage

// File: rtl/p2p_result_collector_if.sv
// Bus between the collector and its surroundings: sample capture in, product stream and status out.
// Handshake: a readout beat transfers on a posedge where out_valid & out_ready; while out_ready=0 the
// collector holds out_data/out_valid/out_last. prod_valid has no backpressure and is sampled every cycle.
interface p2p_result_collector_if;
  import p2p_pkg::*;
  logic [P2P_DW-1:0]    prod_in;
  logic                 prod_valid;
  logic                 done_in;
  logic                 out_ready;
  logic [P2P_DW-1:0]    out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [P2P_SUM_W-1:0] sum_out;
  logic                 sum_valid;
  logic                 busy;
  logic                 overrun;
  st_e                  state;

  modport master (
    output prod_in, prod_valid, done_in, out_ready,
    input  out_data, out_valid, out_last, sum_out, sum_valid, busy, overrun, state
  );
  modport slave (
    input  prod_in, prod_valid, done_in, out_ready,
    output out_data, out_valid, out_last, sum_out, sum_valid, busy, overrun, state
  );
endinterface

// File: rtl/p2p_frame_buf.sv
// Frame buffer: DEPTH x W register file, one write port, one registered read port.
module p2p_frame_buf
  import p2p_pkg::*;
#(
  parameter int DEPTH = P2P_SIZE,
  parameter int W     = P2P_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the collector's out_data reads 0 out of reset; it holds when re=0.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/p2p_result_collector.sv
// Captures a frame of products into a buffer while summing them, then replays the frame
// over a valid/ready stream with a last marker.
module p2p_result_collector
  import p2p_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  p2p_result_collector_if.slave bus
);
  localparam int AW = $clog2(P2P_SIZE);
  localparam logic [P2P_CNT_W-1:0] SIZE_C = P2P_CNT_W'(P2P_SIZE);
  localparam logic [P2P_CNT_W-1:0] ONE_C  = P2P_CNT_W'(1);

  st_e                  state, state_nxt;
  logic [P2P_CNT_W-1:0] wr_cnt, rd_idx;
  logic [P2P_SUM_W-1:0] sum, prod_ext;
  logic                 out_valid_q, out_last_q, overrun_q;
  logic                 full, store, load, fin;
  logic [P2P_DW-1:0]    rdata;
  logic [AW-1:0]        waddr;

  always_comb begin
    prod_ext = {{(P2P_SUM_W-P2P_DW){1'b0}}, bus.prod_in};
    full     = (wr_cnt == SIZE_C);
    store    = bus.prod_valid && (state != ST_READOUT) && !full;
    waddr    = (state == ST_IDLE) ? '0 : wr_cnt[AW-1:0];
    // Fetch the next word when the output register is empty or being drained, unless the last beat is showing.
    load     = (state == ST_READOUT) && (!out_valid_q || bus.out_ready) && !(out_valid_q && out_last_q);
    fin      = (state == ST_READOUT) && out_valid_q && bus.out_ready && out_last_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.prod_valid) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (bus.done_in || full || (store && (wr_cnt + ONE_C == SIZE_C)))
                    state_nxt = ST_READOUT;
      ST_READOUT: if (fin) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_idx      <= '0;
      sum         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (store) begin
        wr_cnt <= (state == ST_IDLE) ? ONE_C : wr_cnt + ONE_C;
        sum    <= (state == ST_IDLE) ? prod_ext : sum + prod_ext;
      end
      if (bus.prod_valid && !store) overrun_q <= 1'b1;
      if (load) begin
        out_valid_q <= 1'b1;
        out_last_q  <= (rd_idx == wr_cnt - ONE_C);
        rd_idx      <= rd_idx + ONE_C;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (fin) begin
        wr_cnt <= '0;
        rd_idx <= '0;
      end
    end
  end

  p2p_frame_buf #(.DEPTH(P2P_SIZE), .W(P2P_DW), .AW(AW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (store),
    .waddr (waddr),
    .wdata (bus.prod_in),
    .re    (load),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.out_data  = rdata;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.sum_out   = sum;
  assign bus.sum_valid = (state == ST_READOUT);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.state     = state;
endmodule
